fm_capture_ctrl: RTL and testbench
==================================

# fm_capture_ctrl

Sequencer for the FM receiver test path. On a start command it selects one of the two test-signal sources, holds the demodulator in reset to flush it, waits a fixed settling period, then captures a window of demodulator output samples. It reports minimum, maximum and peak-to-peak values and raises a one-cycle done pulse. It sits between the test-signal generator and the `fm` demodulator, driving the demodulator's input and reset.

## Interface
Parameters:
- IN_W, 8, FM input sample width
- OUT_W, 12, demodulator output width (two's complement)
- FLUSH_CYC, 4, cycles the demodulator is held in reset (≥1)
- SETTLE_CYC, 256, cycles ignored after flush release (≥1)
- WIN_LEN, 1024, samples per capture window (power of two, ≥2)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a capture run; sampled only in IDLE
- src_sel  in  1  source select: 0 = sine FM, 1 = triangle FM; latched on accepted start
- fm_a  in  IN_W  sine FM test signal
- fm_b  in  IN_W  triangle FM test signal
- fmin  out  IN_W  demodulator input = latched source, registered
- dm_reset  out  1  demodulator reset, active-low
- dmout  in  OUT_W  demodulator output, signed
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when results are valid
- min_val  out  OUT_W  minimum captured sample, signed
- max_val  out  OUT_W  maximum captured sample, signed
- p2p  out  OUT_W+1  max_val − min_val, unsigned

## Operation
- States: IDLE → FLUSH → SETTLE → CAPTURE → REPORT → IDLE.
- IDLE: dm_reset=1, busy=0. On start=1, latch src_sel, clear counters, go to FLUSH.
- FLUSH: dm_reset=0 for exactly FLUSH_CYC cycles, then go to SETTLE.
- SETTLE: dm_reset=1; count SETTLE_CYC cycles; dmout is ignored.
- CAPTURE: take one dmout sample per cycle for WIN_LEN cycles. The first sample initialises min and max. Later samples use a signed compare: update min when the sample is strictly less, max when strictly greater.
- REPORT: register p2p = sign-extended max − sign-extended min (OUT_W+1 bits, never negative). Pulse done for one cycle, then return to IDLE.
- min_val, max_val and p2p hold their values until the next accepted start. They are cleared to 0 on the first CAPTURE sample's cycle.
- fmin always drives the latched source, registered, including in IDLE. This lets the demodulator free-run.
- start while busy=1 is ignored. There is no queueing. src_sel changes during a run have no effect.
- start held high through REPORT: re-accepted in the next IDLE cycle, one cycle after done.

## Timing
- Reset values: fmin=0, dm_reset=0 while reset is asserted, then 1 in IDLE after release. busy=0, done=0, min_val=max_val=0, p2p=0, latched src=0.
- Reset asserted mid-run: immediately return to IDLE. All outputs go to their reset values. No done pulse.
- start accepted in cycle 0. dm_reset goes low in cycles 1..FLUSH_CYC.
- SETTLE occupies the next SETTLE_CYC cycles.
- CAPTURE occupies the next WIN_LEN cycles.
- done is high in cycle 1+FLUSH_CYC+SETTLE_CYC+WIN_LEN. Results are valid in that same cycle.
- busy rises in cycle 1 and falls in the cycle after done.
- fmin latency: one cycle from fm_a/fm_b.
- Counters are sized by $clog2 of their terminal value. No wrap occurs within a state.

## Configuration
- FM_CAPTURE_MEAN_EN defined: adds output `mean_val` (OUT_W, signed).
  - A signed accumulator of width OUT_W+$clog2(WIN_LEN) sums every CAPTURE sample.
  - mean_val = sum >>> $clog2(WIN_LEN), arithmetic shift, truncates toward −∞.
  - mean_val is registered in REPORT, valid with done, reset value 0, holds until the next start.
- Not defined: no accumulator and no mean_val port. All other behaviour is identical.

## Structure
- Shared package `fm_pkg`:
  - state enum (IDLE, FLUSH, SETTLE, CAPTURE, REPORT)
  - source select constants SRC_SINE=0, SRC_TRI=1
  - default widths IN_W and OUT_W
- One sub-module, `fm_minmax_track`, is natural here. It holds the signed min/max registers, with init/update inputs and sample-valid qualification. The FSM and counters stay in the top.

## Test plan
- Reset: assert reset mid-CAPTURE → busy=0, dm_reset=0 during reset, no done, outputs 0. After release, start is accepted normally.
- Basic run: FLUSH_CYC=4, SETTLE_CYC=8, WIN_LEN=16, constant dmout=100 → done at cycle 29 after start; min=max=100, p2p=0.
- Signed extremes: ramp dmout from −2048 to +2047 during CAPTURE → min=−2048, max=2047, p2p=4095 (no overflow).
- Source select: src_sel=1 at start, toggle src_sel during run → fmin tracks fm_b, delayed one cycle, for the whole run.
- Start handling: start pulses during SETTLE are ignored. start held high continuously gives back-to-back runs with exactly one IDLE cycle between done and busy.
- FM_CAPTURE_MEAN_EN: WIN_LEN=4, samples −3, −2, −2, −2 → sum −9, mean_val=−3. Samples 1, 2, 3, 4 → mean_val=2.

Source files
------------

// File: rtl/fm_pkg.sv
// fm_pkg: shared state encoding, source-select constants and sizing helpers
// for the FM test-path capture sequencer (fm_capture_ctrl).
`default_nettype none

package fm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLUSH   = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    REPORT  = 3'd4
  } state_t;

  localparam logic SRC_SINE = 1'b0;
  localparam logic SRC_TRI  = 1'b1;

  localparam int DEF_IN_W  = 8;
  localparam int DEF_OUT_W = 12;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fm_capture_ctrl_if.sv
// fm_capture_ctrl_if: command, source, demodulator and result signals of the
// capture sequencer. mean_val exists only when FM_CAPTURE_MEAN_EN is defined.
`default_nettype none

interface fm_capture_ctrl_if
  import fm_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) ();

  logic             start;
  logic             src_sel;
  logic [IN_W-1:0]  fm_a;
  logic [IN_W-1:0]  fm_b;
  logic [IN_W-1:0]  fmin;
  logic             dm_reset;
  logic [OUT_W-1:0] dmout;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] min_val;
  logic [OUT_W-1:0] max_val;
  logic [OUT_W:0]   p2p;
`ifdef FM_CAPTURE_MEAN_EN
  logic [OUT_W-1:0] mean_val;
`endif

  modport master (
    output start, src_sel, fm_a, fm_b, dmout,
    input  fmin, dm_reset, busy, done, min_val, max_val, p2p
`ifdef FM_CAPTURE_MEAN_EN
    , input mean_val
`endif
  );

  modport slave (
    input  start, src_sel, fm_a, fm_b, dmout,
    output fmin, dm_reset, busy, done, min_val, max_val, p2p
`ifdef FM_CAPTURE_MEAN_EN
    , output mean_val
`endif
  );

endinterface

`default_nettype wire

// File: rtl/fm_minmax_track.sv
// fm_minmax_track: signed running minimum/maximum over qualified samples,
// with synchronous clear and first-sample initialisation.
`default_nettype none

module fm_minmax_track #(
  parameter int W = 12
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                clr_i,
  input  wire logic                valid_i,
  input  wire logic                init_i,
  input  wire logic signed [W-1:0] sample_i,
  output logic signed [W-1:0]      min_o,
  output logic signed [W-1:0]      max_o,
  output logic signed [W-1:0]      min_nxt_o,
  output logic signed [W-1:0]      max_nxt_o
);

  logic signed [W-1:0] min_q, min_d;
  logic signed [W-1:0] max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (clr_i) begin
      min_d = '0;
      max_d = '0;
    end else if (valid_i) begin
      if (init_i) begin
        min_d = sample_i;
        max_d = sample_i;
      end else begin
        if (sample_i < min_q) min_d = sample_i;
        if (sample_i > max_q) max_d = sample_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_o     = min_q;
  assign max_o     = max_q;
  assign min_nxt_o = min_d;
  assign max_nxt_o = max_d;

endmodule

`default_nettype wire

// File: rtl/fm_capture_ctrl.sv
// fm_capture_ctrl: flush / settle / capture sequencer for the FM demodulator
// test path. Optional mean output enabled by FM_CAPTURE_MEAN_EN.
`default_nettype none

module fm_capture_ctrl
  import fm_pkg::*;
#(
  parameter int IN_W       = DEF_IN_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int FLUSH_CYC  = 4,
  parameter int SETTLE_CYC = 256,
  parameter int WIN_LEN    = 1024
) (
  input wire logic          clk,
  input wire logic          reset,
  fm_capture_ctrl_if.slave  bus
);

  localparam int CNT_W = cnt_width(max3(FLUSH_CYC, SETTLE_CYC, WIN_LEN));
  localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WIN_LEN - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               src_q, src_d;
  logic [IN_W-1:0]    fmin_q, fmin_d;
  logic               dm_reset_q, dm_reset_d;
  logic [OUT_W:0]     p2p_q, p2p_d;

  logic               w_clr;
  logic               w_last_cap;
  logic               w_capture;
  logic               w_first;
  logic [OUT_W-1:0]   w_min, w_max, w_min_nxt, w_max_nxt;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    src_d      = src_q;
    w_clr      = 1'b0;
    w_last_cap = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d = FLUSH;
          src_d   = bus.src_sel;
        end
      end
      FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = CAPTURE;
          cnt_d   = '0;
          w_clr   = 1'b1;
        end
      end
      CAPTURE: begin
        if (cnt_q == WIN_LAST) begin
          state_d    = REPORT;
          cnt_d      = '0;
          w_last_cap = 1'b1;
        end
      end
      REPORT: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign w_capture = (state_q == CAPTURE);
  assign w_first   = (cnt_q == '0);

  // Source follows the newly latched selection from the cycle the start is accepted.
  assign fmin_d     = (src_d == SRC_TRI) ? bus.fm_b : bus.fm_a;
  assign dm_reset_d = (state_d != FLUSH);

  fm_minmax_track #(
    .W (OUT_W)
  ) u_minmax (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (w_clr),
    .valid_i   (w_capture),
    .init_i    (w_first),
    .sample_i  ($signed(bus.dmout)),
    .min_o     (w_min),
    .max_o     (w_max),
    .min_nxt_o (w_min_nxt),
    .max_nxt_o (w_max_nxt)
  );

  // Loaded from the tracker's next values so p2p is valid alongside done.
  always_comb begin
    p2p_d = p2p_q;
    if (w_clr) begin
      p2p_d = '0;
    end else if (w_last_cap) begin
      p2p_d = {w_max_nxt[OUT_W-1], w_max_nxt} - {w_min_nxt[OUT_W-1], w_min_nxt};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      src_q      <= SRC_SINE;
      fmin_q     <= '0;
      dm_reset_q <= 1'b0;
      p2p_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      src_q      <= src_d;
      fmin_q     <= fmin_d;
      dm_reset_q <= dm_reset_d;
      p2p_q      <= p2p_d;
    end
  end

`ifdef FM_CAPTURE_MEAN_EN
  localparam int LOG2W = $clog2(WIN_LEN);
  localparam int ACC_W = OUT_W + LOG2W;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] w_samp_ext;
  logic [OUT_W-1:0]        mean_q, mean_d;

  assign w_samp_ext = {{LOG2W{bus.dmout[OUT_W-1]}}, bus.dmout};

  always_comb begin
    acc_d = acc_q;
    if (w_capture) begin
      acc_d = (w_first ? '0 : acc_q) + w_samp_ext;
    end
  end

  // Dropping the low LOG2W bits of the sum is an arithmetic shift that floors.
  always_comb begin
    mean_d = mean_q;
    if (w_last_cap) begin
      mean_d = acc_d[ACC_W-1:LOG2W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      mean_q <= '0;
    end else begin
      acc_q  <= acc_d;
      mean_q <= mean_d;
    end
  end

  assign bus.mean_val = mean_q;
`endif

  assign bus.fmin     = fmin_q;
  assign bus.dm_reset = dm_reset_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == REPORT);
  assign bus.min_val  = w_min;
  assign bus.max_val  = w_max;
  assign bus.p2p      = p2p_q;

endmodule

`default_nettype wire

// File: tb/tb_fm_capture_ctrl.sv
// tb_fm_capture_ctrl: directed vector table plus hand sequences for reset,
// back-to-back starts and (with FM_CAPTURE_MEAN_EN) the mean output.
`default_nettype none

module tb_fm_capture_ctrl;
  import fm_pkg::*;

  localparam int F        = 4;
  localparam int S        = 8;
  localparam int W        = 16;
  localparam int DONE_CYC = 1 + F + S + W;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fm_capture_ctrl_if #(.IN_W(8), .OUT_W(12)) bus ();

  fm_capture_ctrl #(
    .IN_W(8), .OUT_W(12), .FLUSH_CYC(F), .SETTLE_CYC(S), .WIN_LEN(W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef FM_CAPTURE_MEAN_EN
  fm_capture_ctrl_if #(.IN_W(8), .OUT_W(12)) bus2 ();

  fm_capture_ctrl #(
    .IN_W(8), .OUT_W(12), .FLUSH_CYC(F), .SETTLE_CYC(S), .WIN_LEN(4)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic src;
    int   pulse_cyc;
    int   base;
    int   step;
    int   exp_min;
    int   exp_max;
    int   exp_p2p;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v, input string tag);
    int done_cyc   = -1;
    int done_cnt   = 0;
    int dm_low     = 0;
    int dm_first   = -1;
    int busy_first = -1;
    int busy_fall  = -1;
    int fmin_err   = 0;
    int idx;
    logic [7:0] pa, pb;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.src_sel = v.src;
    pa = 8'($urandom);
    pb = 8'($urandom);
    bus.fm_a  = pa;
    bus.fm_b  = pb;
    bus.dmout = 12'h7FF;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (!bus.dm_reset) begin
        dm_low++;
        if (dm_first < 0) dm_first = k;
      end
      if (bus.busy && busy_first < 0) busy_first = k;
      if (!bus.busy && busy_first >= 0 && busy_fall < 0) busy_fall = k;
      if (bus.fmin !== (v.src ? pb : pa)) fmin_err++;
      bus.start   = (k == v.pulse_cyc);
      bus.src_sel = ~bus.src_sel;
      pa = 8'($urandom);
      pb = 8'($urandom);
      bus.fm_a = pa;
      bus.fm_b = pb;
      idx = k - (F + S + 1);
      if (idx >= 0 && idx < W) bus.dmout = 12'(v.base + v.step * idx);
      else                     bus.dmout = (k % 2 == 1) ? 12'h7FF : 12'h800;
    end
    chk({tag, " done_cycle"}, done_cyc, DONE_CYC);
    chk({tag, " done_width"}, done_cnt, 1);
    chk({tag, " dm_reset_first_low"}, dm_first, 1);
    chk({tag, " dm_reset_low_cycles"}, dm_low, F);
    chk({tag, " busy_rise"}, busy_first, 1);
    chk({tag, " busy_fall"}, busy_fall, DONE_CYC + 1);
    chk({tag, " min_val"}, int'($signed(bus.min_val)), v.exp_min);
    chk({tag, " max_val"}, int'($signed(bus.max_val)), v.exp_max);
    chk({tag, " p2p"}, int'(bus.p2p), v.exp_p2p);
    chk({tag, " fmin_errors"}, fmin_err, 0);
  endtask

`ifdef FM_CAPTURE_MEAN_EN
  task automatic run_mean(input int s0, input int s1, input int s2, input int s3,
                          input int exp_mean, input string tag);
    int smp[4];
    int done_cyc = -1;
    int mean_at  = 9999;
    smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
    @(negedge clk);
    bus2.start = 1'b1;
    bus2.dmout = 12'h7FF;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (bus2.done && done_cyc < 0) begin
        done_cyc = k;
        mean_at  = int'($signed(bus2.mean_val));
      end
      bus2.start = 1'b0;
      if (k >= F + S + 1 && k <= F + S + 4) bus2.dmout = 12'(smp[k - (F + S + 1)]);
      else                                  bus2.dmout = 12'h7FF;
    end
    chk({tag, " done_cycle"}, done_cyc, 1 + F + S + 4);
    chk({tag, " mean_val"}, mean_at, exp_mean);
  endtask
`endif

  initial begin
    int done_seen;
    int busy_low;
    int d1;
    int d2;

    vecs[0] = '{src: 1'b0, pulse_cyc: 0,  base: 100,   step: 0,   exp_min: 100,   exp_max: 100,  exp_p2p: 0};
    vecs[1] = '{src: 1'b1, pulse_cyc: 8,  base: -2048, step: 273, exp_min: -2048, exp_max: 2047, exp_p2p: 4095};
    vecs[2] = '{src: 1'b0, pulse_cyc: 10, base: 50,    step: -10, exp_min: -100,  exp_max: 50,   exp_p2p: 150};
    vecs[3] = '{src: 1'b1, pulse_cyc: 0,  base: -1,    step: 0,   exp_min: -1,    exp_max: -1,   exp_p2p: 0};
    vecs[4] = '{src: 1'b0, pulse_cyc: 12, base: 1000,  step: -1,  exp_min: 985,   exp_max: 1000, exp_p2p: 15};

    bus.start   = 1'b0;
    bus.src_sel = 1'b0;
    bus.fm_a    = 8'h5A;
    bus.fm_b    = 8'hA5;
    bus.dmout   = '0;
`ifdef FM_CAPTURE_MEAN_EN
    bus2.start   = 1'b0;
    bus2.src_sel = 1'b0;
    bus2.fm_a    = '0;
    bus2.fm_b    = '0;
    bus2.dmout   = '0;
`endif

    #2 reset = 1'b0;
    #10;
    chk("rst busy", int'(bus.busy), 0);
    chk("rst dm_reset", int'(bus.dm_reset), 0);
    chk("rst done", int'(bus.done), 0);
    chk("rst fmin", int'(bus.fmin), 0);
    chk("rst min_val", int'(bus.min_val), 0);
    chk("rst max_val", int'(bus.max_val), 0);
    chk("rst p2p", int'(bus.p2p), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle dm_reset", int'(bus.dm_reset), 1);
    chk("idle fmin sine", int'(bus.fmin), 8'h5A);

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // start held high: two back-to-back runs with a single idle cycle between
    @(negedge clk);
    bus.start = 1'b1;
    bus.dmout = 12'd100;
    done_seen = 0;
    busy_low  = 0;
    d1 = -1;
    d2 = -1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (bus.done) begin
        done_seen++;
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      if (!bus.busy && k < 60) busy_low++;
      bus.start = (k < 59);
    end
    chk("b2b first done", d1, DONE_CYC);
    chk("b2b second done", d2, 2 * DONE_CYC + 1);
    chk("b2b done count", done_seen, 2);
    chk("b2b idle cycles", busy_low, 1);

    // reset asserted during CAPTURE
    @(negedge clk);
    bus.start   = 1'b1;
    bus.src_sel = 1'b1;
    bus.dmout   = 12'd100;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("mid min before reset", int'($signed(bus.min_val)), 100);
    reset = 1'b0;
    #1;
    chk("mid rst busy", int'(bus.busy), 0);
    chk("mid rst dm_reset", int'(bus.dm_reset), 0);
    chk("mid rst done", int'(bus.done), 0);
    chk("mid rst min_val", int'(bus.min_val), 0);
    chk("mid rst max_val", int'(bus.max_val), 0);
    chk("mid rst p2p", int'(bus.p2p), 0);
    chk("mid rst fmin", int'(bus.fmin), 0);
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    chk("mid rst quiet", done_seen, 0);
    reset = 1'b1;
    @(negedge clk);
    run_vec(vecs[2], "post_reset");

`ifdef FM_CAPTURE_MEAN_EN
    run_mean(-3, -2, -2, -2, -3, "mean_neg");
    run_mean(1, 2, 3, 4, 2, "mean_pos");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
